ram_loader: RTL and testbench

Front-end write stage for the solver's dual-read/single-write RAM. Accepts a framed stream of N-bit words over a valid/ready handshake (base address, word count, payload) and drives the RAM write port so the payload lands at consecutive addresses from the base. Sits directly upstream of the RAM's write port: coefficient tables and initial conditions are preloaded through it before the solver datapath starts issuing reads.

---
 rtl/ode_ram_pkg.sv | 16 +
 rtl/ram_loader_ctrl.sv | 86 ++++++++
 rtl/ram_loader.sv | 127 ++++++++++++
 tb/tb_ram_loader.sv | 365 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ode_ram_pkg.sv
// rtl/ode_ram_pkg.sv - shared RAM geometry and loader state encoding for the solver RAM
package ode_ram_pkg;

  localparam int RAM_N = 16;    // data word width
  localparam int RAM_M = 6000;  // RAM depth in words
  localparam int RAM_K = 13;    // RAM address width

  typedef enum logic [2:0] {
    ST_ADDR,
    ST_LEN,
    ST_DATA,
    ST_CSUM,
    ST_DONE
  } load_state_t;

endpackage

// File: rtl/ram_loader_ctrl.sv
// rtl/ram_loader_ctrl.sv - frame state machine and stream handshake for ram_loader (CSUM state under RAM_LOADER_CHECKSUM_EN)
module ram_loader_ctrl
  import ode_ram_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        valid,
  input  logic        len_zero,
  input  logic        last_word,
  output logic        ready,
  output logic        accept,
  output load_state_t state,
  output logic        busy,
  output logic        done
);

  // After the payload the frame closes either through the checksum word or directly.
`ifdef RAM_LOADER_CHECKSUM_EN
  localparam load_state_t CLOSE_STATE   = ST_CSUM;
  localparam logic        CLOSE_IS_DONE = 1'b0;
`else
  localparam load_state_t CLOSE_STATE   = ST_DONE;
  localparam logic        CLOSE_IS_DONE = 1'b1;
`endif

  // Ready in every state except the single DONE cycle, and never while held in reset.
  always_comb begin
    ready  = rst_n && (state != ST_DONE);
    accept = valid && ready;
  end

  // Frame sequencing; busy and done are registered together with the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_ADDR;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_ADDR: begin
          if (accept) begin
            state <= ST_LEN;
            busy  <= 1'b1;
          end
        end
        ST_LEN: begin
          if (accept) begin
            if (len_zero) begin
              state <= CLOSE_STATE;
              if (CLOSE_IS_DONE) begin
                busy <= 1'b0;
                done <= 1'b1;
              end
            end else begin
              state <= ST_DATA;
            end
          end
        end
        ST_DATA: begin
          if (accept && last_word) begin
            state <= CLOSE_STATE;
            if (CLOSE_IS_DONE) begin
              busy <= 1'b0;
              done <= 1'b1;
            end
          end
        end
        ST_CSUM: begin
          if (accept) begin
            state <= ST_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        ST_DONE: begin
          state <= ST_ADDR;
        end
        default: begin
          state <= ST_ADDR;
        end
      endcase
    end
  end

endmodule

// File: rtl/ram_loader.sv
// rtl/ram_loader.sv - framed stream to RAM write-port loader (checksum word and csumErr under RAM_LOADER_CHECKSUM_EN)
module ram_loader
  import ode_ram_pkg::*;
#(
  parameter int N = RAM_N,
  parameter int M = RAM_M,
  parameter int K = RAM_K
) (
  input  logic         Clk,
  input  logic         Rst,
  input  logic [N-1:0] inData,
  input  logic         inValid,
  output logic         inReady,
  output logic         WE,
  output logic [K-1:0] addressWritePort,
  output logic [N-1:0] writePortData,
  output logic         busy,
  output logic         done,
  output logic         rangeErr
`ifdef RAM_LOADER_CHECKSUM_EN
  ,
  output logic         csumErr
`endif
);

  // Depth compare is done one bit wider than the address so M is representable.
  localparam logic [K:0] DEPTH = (K + 1)'(M);

  load_state_t  state;
  logic         accept;
  logic [K-1:0] base;
  logic [K-1:0] ptr;
  logic [N-1:0] remaining;
  logic         in_range;
  logic         len_zero;
  logic         last_word;

  ram_loader_ctrl u_ctrl (
    .clk       (Clk),
    .rst_n     (Rst),
    .valid     (inValid),
    .len_zero  (len_zero),
    .last_word (last_word),
    .ready     (inReady),
    .accept    (accept),
    .state     (state),
    .busy      (busy),
    .done      (done)
  );

  // Range and length decodes consumed by the state machine and the write path.
  always_comb begin
    in_range  = {1'b0, ptr} < DEPTH;
    len_zero  = (inData == '0);
    last_word = (remaining == N'(1));
  end

  // Header capture, write pointer walk and registered RAM write port.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      base             <= '0;
      ptr              <= '0;
      remaining        <= '0;
      WE               <= 1'b0;
      addressWritePort <= '0;
      writePortData    <= '0;
      rangeErr         <= 1'b0;
    end else begin
      WE <= 1'b0;
      if (accept) begin
        case (state)
          ST_ADDR: begin
            base     <= inData[K-1:0];
            rangeErr <= 1'b0;
          end
          ST_LEN: begin
            ptr       <= base;
            remaining <= inData;
          end
          ST_DATA: begin
            // Out-of-range words are swallowed so the stream stays framed.
            if (in_range) begin
              WE               <= 1'b1;
              addressWritePort <= ptr;
              writePortData    <= inData;
            end else begin
              rangeErr <= 1'b1;
            end
            // Saturate instead of wrapping so an overrun can never alias low addresses.
            if (ptr != '1) begin
              ptr <= ptr + K'(1);
            end
            remaining <= remaining - N'(1);
          end
          default: begin
          end
        endcase
      end
    end
  end

`ifdef RAM_LOADER_CHECKSUM_EN
  logic [N-1:0] sum;

  // Running mod-2^N payload sum, compared against the trailing checksum word.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      sum     <= '0;
      csumErr <= 1'b0;
    end else if (accept) begin
      case (state)
        ST_ADDR: csumErr <= 1'b0;
        ST_LEN:  sum <= '0;
        ST_DATA: sum <= sum + inData;
        ST_CSUM: begin
          if (inData != sum) begin
            csumErr <= 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_ram_loader.sv
// tb/tb_ram_loader.sv - self-checking bench for ram_loader (follows RAM_LOADER_CHECKSUM_EN)
module tb_ram_loader;

  localparam int N = 16;
  localparam int M = 6000;
  localparam int K = 13;
  localparam int AMAX = (1 << K) - 1;
`ifdef RAM_LOADER_CHECKSUM_EN
  localparam int CSUM_EXTRA = 1;
`else
  localparam int CSUM_EXTRA = 0;
`endif

  logic         Clk = 1'b0;
  logic         Rst;
  logic [N-1:0] inData;
  logic         inValid;
  logic         inReady;
  logic         WE;
  logic [K-1:0] addressWritePort;
  logic [N-1:0] writePortData;
  logic         busy;
  logic         done;
  logic         rangeErr;
`ifdef RAM_LOADER_CHECKSUM_EN
  logic         csumErr;
`endif

  ram_loader dut (
    .Clk              (Clk),
    .Rst              (Rst),
    .inData           (inData),
    .inValid          (inValid),
    .inReady          (inReady),
    .WE               (WE),
    .addressWritePort (addressWritePort),
    .writePortData    (writePortData),
    .busy             (busy),
    .done             (done),
    .rangeErr         (rangeErr)
`ifdef RAM_LOADER_CHECKSUM_EN
    ,
    .csumErr          (csumErr)
`endif
  );

  always #5 Clk = ~Clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always @(posedge Clk) cyc <= cyc + 1;

  // RAM behind the write port
  bit [N-1:0] dut_ram [0:AMAX];
  bit         dut_wr  [0:AMAX];
  bit [N-1:0] ref_ram [0:AMAX];
  bit         ref_wr  [0:AMAX];

  always @(posedge Clk) begin
    if (WE) begin
      dut_ram[addressWritePort] <= writePortData;
      dut_wr[addressWritePort]  <= 1'b1;
    end
  end

  // observation log, sampled mid-cycle
  typedef struct {
    int addr;
    int data;
    int cyc;
  } wr_t;

  wr_t wlog[$];
  int  mon_nready = 0;
  int  mon_done = 0;
  int  done_cyc = 0;
  bit  range_at_done = 1'b0;
  bit  csum_at_done = 1'b0;

  always @(negedge Clk) begin
    if (Rst) begin
      if (!inReady) mon_nready++;
      if (done) begin
        mon_done++;
        done_cyc = cyc;
        range_at_done = rangeErr;
`ifdef RAM_LOADER_CHECKSUM_EN
        csum_at_done = csumErr;
`endif
      end
      if (WE) wlog.push_back('{int'(addressWritePort), int'(writePortData), cyc});
    end
  end

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Present one word after 'gap' idle cycles; returns the cycle number of the accepting edge.
  task automatic send_word(input logic [N-1:0] w, input int gap, output int acc_cyc);
    inValid = 1'b0;
    repeat (gap) begin
      @(posedge Clk);
      #1;
    end
    inValid = 1'b1;
    inData  = w;
    acc_cyc = -1;
    for (int i = 0; i < 20 && acc_cyc < 0; i++) begin
      @(negedge Clk);
      if (inReady) begin
        @(posedge Clk);
        #1;
        acc_cyc = cyc;
      end else begin
        @(posedge Clk);
        #1;
      end
    end
    inValid = 1'b0;
    if (acc_cyc < 0) chk("accept_timeout", 0, 1);
  endtask

  // Send one frame, check it against the reference model and update the reference RAM.
  task automatic run_frame(input string tag, input logic [N-1:0] base_w, input logic [N-1:0] pay[$],
                           input int gaps[$], input bit bad_csum,
                           output int n_wr, output int cycles, output bit rng);
    logic [N-1:0] words[$];
    logic [N-1:0] sum;
    int exp_a[$];
    int exp_d[$];
    bit exp_rng;
    int a;
    int d0;
    int r0;
    int l0;
    int acc;
    int hdr_cyc;
    int gap_hdr;
    int gap_data;
    int cnt;

    cnt = pay.size();
    sum = '0;
    words.push_back(base_w);
    words.push_back(N'(cnt));
    foreach (pay[i]) begin
      words.push_back(pay[i]);
      sum += pay[i];
    end
    if (CSUM_EXTRA != 0) words.push_back(sum + N'(bad_csum));

    // reference: payload i goes to base+i (saturating at the top address), dropped at or beyond M
    exp_rng = 1'b0;
    for (int i = 0; i < cnt; i++) begin
      a = int'(base_w[K-1:0]) + i;
      if (a > AMAX) a = AMAX;
      if (a < M) begin
        exp_a.push_back(a);
        exp_d.push_back(int'(pay[i]));
      end else begin
        exp_rng = 1'b1;
      end
    end

    gap_hdr = 0;
    gap_data = 0;
    for (int i = 1; i < words.size(); i++) begin
      if (i < gaps.size()) begin
        gap_hdr += gaps[i];
        if (i >= 3 && i <= cnt + 1) gap_data += gaps[i];
      end
    end

    d0 = mon_done;
    r0 = mon_nready;
    l0 = wlog.size();
    hdr_cyc = 0;
    for (int i = 0; i < words.size(); i++) begin
      send_word(words[i], (i < gaps.size()) ? gaps[i] : 0, acc);
      if (i == 0) hdr_cyc = acc;
    end
    for (int i = 0; i < 6 && mon_done == d0; i++) @(negedge Clk);
    @(posedge Clk);
    #1;

    n_wr = wlog.size() - l0;
    cycles = done_cyc - hdr_cyc + 2;
    rng = range_at_done;

    chk($sformatf("%s done_pulses", tag), mon_done - d0, 1);
    chk($sformatf("%s ready_low_cycles", tag), mon_nready - r0, 1);
    chk($sformatf("%s write_count", tag), n_wr, exp_a.size());
    for (int i = 0; i < exp_a.size() && i < n_wr; i++) begin
      chk($sformatf("%s wr%0d_addr", tag, i), wlog[l0 + i].addr, exp_a[i]);
      chk($sformatf("%s wr%0d_data", tag, i), wlog[l0 + i].data, exp_d[i]);
    end
    chk($sformatf("%s range_err", tag), rng, exp_rng);
    chk($sformatf("%s cycles", tag), cycles, cnt + 3 + CSUM_EXTRA + gap_hdr);
    chk($sformatf("%s busy_after", tag), busy, 0);
    if (cnt > 0 && exp_a.size() == cnt && n_wr == cnt)
      chk($sformatf("%s we_span", tag), wlog[l0 + n_wr - 1].cyc - wlog[l0].cyc + 1, cnt + gap_data);
`ifdef RAM_LOADER_CHECKSUM_EN
    chk($sformatf("%s csum_err", tag), csum_at_done, bad_csum);
`endif

    foreach (exp_a[i]) begin
      ref_ram[exp_a[i]] = N'(exp_d[i]);
      ref_wr[exp_a[i]]  = 1'b1;
    end
  endtask

  typedef struct {
    logic [N-1:0] base;
    int count;
    int first;
    int gap_word;
    int gap_len;
    int exp_writes;
    bit exp_range;
    int exp_cycles;
  } vec_t;

  vec_t vecs[8];

  initial begin
    logic [N-1:0] pay[$];
    int gaps[$];
    int n_wr;
    int cycles;
    int acc;
    int mism;
    int sel;
    int base13;
    bit rng;
    bit bad;

    Rst = 1'b0;
    inValid = 1'b0;
    inData = '0;

    vecs[0] = '{16'd0,     5, 10,  -1, 0, 5, 1'b0, 8};
    vecs[1] = '{16'd0,     5, 10,   4, 2, 5, 1'b0, 10};
    vecs[2] = '{16'd5998,  4, 1,   -1, 0, 2, 1'b1, 7};
    vecs[3] = '{16'd0,     1, 7,   -1, 0, 1, 1'b0, 4};
    vecs[4] = '{16'd100,   0, 0,   -1, 0, 0, 1'b0, 3};
    vecs[5] = '{16'd8190,  3, 20,  -1, 0, 0, 1'b1, 6};
    vecs[6] = '{16'd5995,  5, 200, -1, 0, 5, 1'b0, 8};
    vecs[7] = '{16'hE003,  2, 30,  -1, 0, 2, 1'b0, 5};

    // reset state
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    chk("rst_inReady", inReady, 0);
    chk("rst_WE", WE, 0);
    chk("rst_addr", addressWritePort, 0);
    chk("rst_data", writePortData, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_rangeErr", rangeErr, 0);
`ifdef RAM_LOADER_CHECKSUM_EN
    chk("rst_csumErr", csumErr, 0);
`endif
    @(posedge Clk);
    #1;
    Rst = 1'b1;
    @(posedge Clk);
    #1;

    // table-driven frames
    foreach (vecs[v]) begin
      pay.delete();
      gaps.delete();
      for (int i = 0; i < vecs[v].count; i++) pay.push_back(N'(vecs[v].first + i));
      for (int i = 0; i < vecs[v].count + 2 + CSUM_EXTRA; i++)
        gaps.push_back((i == vecs[v].gap_word) ? vecs[v].gap_len : 0);
      run_frame($sformatf("vec%0d", v), vecs[v].base, pay, gaps, 1'b0, n_wr, cycles, rng);
      chk($sformatf("vec%0d table_writes", v), n_wr, vecs[v].exp_writes);
      chk($sformatf("vec%0d table_range", v), rng, vecs[v].exp_range);
      chk($sformatf("vec%0d table_cycles", v), cycles, vecs[v].exp_cycles + CSUM_EXTRA);
    end

`ifdef RAM_LOADER_CHECKSUM_EN
    // checksum good then bad; payload lands either way
    pay = '{16'd1, 16'd2, 16'd3};
    gaps.delete();
    run_frame("csum_good", 16'd0, pay, gaps, 1'b0, n_wr, cycles, rng);
    run_frame("csum_bad", 16'd0, pay, gaps, 1'b1, n_wr, cycles, rng);
    chk("csum_bad writes", n_wr, 3);
`endif

    // reset in the middle of a frame after two payload words have been written
    send_word(16'd40, 0, acc);
    send_word(16'd5, 0, acc);
    send_word(16'h1111, 0, acc);
    send_word(16'h2222, 0, acc);
    @(posedge Clk);
    #1;
    chk("mid_busy", busy, 1);
    chk("mid_addr", addressWritePort, 41);
    #2;
    Rst = 1'b0;
    #1;
    chk("mid_rst_inReady", inReady, 0);
    chk("mid_rst_WE", WE, 0);
    chk("mid_rst_addr", addressWritePort, 0);
    chk("mid_rst_data", writePortData, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_rangeErr", rangeErr, 0);
    @(posedge Clk);
    #1;
    Rst = 1'b1;
    ref_ram[40] = 16'h1111;
    ref_wr[40]  = 1'b1;
    ref_ram[41] = 16'h2222;
    ref_wr[41]  = 1'b1;
    pay = '{16'd99};
    gaps.delete();
    run_frame("after_rst", 16'd50, pay, gaps, 1'b0, n_wr, cycles, rng);

    // randomized frames against the reference model
    for (int f = 0; f < 24; f++) begin
      sel = $urandom_range(0, 3);
      case (sel)
        0: base13 = $urandom_range(0, M - 13);
        1: base13 = $urandom_range(M - 10, M - 1);
        2: base13 = $urandom_range(AMAX - 6, AMAX);
        default: base13 = $urandom_range(0, AMAX);
      endcase
      pay.delete();
      gaps.delete();
      for (int i = $urandom_range(0, 10); i > 0; i--) pay.push_back(N'($urandom));
      for (int i = 0; i < pay.size() + 2 + CSUM_EXTRA; i++)
        gaps.push_back(($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0);
      bad = (CSUM_EXTRA != 0) ? 1'($urandom_range(0, 1)) : 1'b0;
      run_frame($sformatf("rnd%0d", f), N'(($urandom_range(0, 7) << K) | base13), pay, gaps, bad,
                n_wr, cycles, rng);
    end

    // whole-RAM comparison
    mism = 0;
    for (int a = 0; a <= AMAX; a++) begin
      if (dut_wr[a] != ref_wr[a]) mism++;
      else if (ref_wr[a] && dut_ram[a] != ref_ram[a]) mism++;
    end
    chk("ram_final_mismatches", mism, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
